// File: rtl/udp_rx.sv
// udp_rx: splits a byte-wide UDP datagram stream (IP layer already removed)
// into a header channel and a length-checked, registered payload stream.
//
// Handshake semantics for every channel in this block: a beat transfers on
// the rising clock edge where valid && ready are both high; a source holds
// valid and its data stable until that edge, and ready may depend on state.
module udp_rx #(
    parameter int AXI_DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    output logic                      m_udp_hdr_tvalid,
    input  logic                      m_udp_hdr_trdy,
    output logic [15:0]               m_udp_src_port,
    output logic [15:0]               m_udp_dst_port,
    output logic [15:0]               m_udp_length,
    output logic [15:0]               m_udp_hdr_checksum,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_trdy,
    output logic                      o_hdr_err,
    output logic                      o_len_err
);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_HDR_OUT = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [15:0]               src_q, src_d;
    logic [15:0]               dst_q, dst_d;
    logic [15:0]               len_q, len_d;
    logic [15:0]               csum_q, csum_d;
    logic [15:0]               rem_q, rem_d;
    logic                      hdr_last_q, hdr_last_d;
    logic                      hdr_valid_q, hdr_valid_d;
    logic [AXI_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                      m_valid_q, m_valid_d;
    logic                      m_last_q, m_last_d;
    logic                      hdr_err_q, hdr_err_d;
    logic                      len_err_q, len_err_d;
    logic                      trdy_c;
    logic                      beat_c;

    // Next-state, header capture, payload stage and error pulse logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        csum_d      = csum_q;
        rem_d       = rem_q;
        hdr_last_d  = hdr_last_q;
        hdr_valid_d = hdr_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        // The output register drains on its own; only PAYLOAD refills it,
        // so a held final byte survives while the next header is parsed.
        m_valid_d   = m_valid_q && !m_axis_trdy;
        hdr_err_d   = 1'b0;
        len_err_d   = 1'b0;
        trdy_c      = 1'b0;

        case (state_q)
            ST_HDR: begin
                trdy_c = 1'b1;
                if (s_axis_tvalid) begin
                    case (cnt_q)
                        3'd0:    src_d  = {s_axis_tdata, src_q[7:0]};
                        3'd1:    src_d  = {src_q[15:8], s_axis_tdata};
                        3'd2:    dst_d  = {s_axis_tdata, dst_q[7:0]};
                        3'd3:    dst_d  = {dst_q[15:8], s_axis_tdata};
                        3'd4:    len_d  = {s_axis_tdata, len_q[7:0]};
                        3'd5:    len_d  = {len_q[15:8], s_axis_tdata};
                        3'd6:    csum_d = {s_axis_tdata, csum_q[7:0]};
                        default: csum_d = {csum_q[15:8], s_axis_tdata};
                    endcase
                    if (cnt_q == 3'd7) begin
                        cnt_d = 3'd0;
                        // Length bytes are complete once byte 7 arrives.
                        if (len_q < 16'd8) begin
                            hdr_err_d = 1'b1;
                            state_d   = s_axis_tlast ? ST_HDR : ST_DROP;
                        end else begin
                            rem_d       = len_q - 16'd8;
                            hdr_valid_d = 1'b1;
                            hdr_last_d  = s_axis_tlast;
                            state_d     = ST_HDR_OUT;
                        end
                    end else if (s_axis_tlast) begin
                        hdr_err_d = 1'b1;
                        cnt_d     = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_HDR_OUT: begin
                if (m_udp_hdr_trdy) begin
                    hdr_valid_d = 1'b0;
                    if (rem_q == 16'd0) begin
                        if (!hdr_last_q) begin
                            len_err_d = 1'b1;
                            state_d   = ST_DROP;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else if (hdr_last_q) begin
                        len_err_d = 1'b1;
                        state_d   = ST_HDR;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                trdy_c = !m_valid_q || m_axis_trdy;
                if (s_axis_tvalid && trdy_c) begin
                    m_data_d  = s_axis_tdata;
                    m_valid_d = 1'b1;
                    m_last_d  = (rem_q == 16'd1) || s_axis_tlast;
                    rem_d     = rem_q - 16'd1;
                    if (s_axis_tlast) begin
                        // Early tlast is a length error; tlast on the final
                        // counted byte is the normal end of datagram.
                        len_err_d = (rem_q != 16'd1);
                        state_d   = ST_HDR;
                    end else if (rem_q == 16'd1) begin
                        len_err_d = 1'b1;
                        state_d   = ST_DROP;
                    end
                end
            end
            default: begin
                trdy_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_HDR;
                end
            end
        endcase
    end

    // All state and output registers; reset clears everything.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_HDR;
            cnt_q       <= 3'd0;
            src_q       <= 16'd0;
            dst_q       <= 16'd0;
            len_q       <= 16'd0;
            csum_q      <= 16'd0;
            rem_q       <= 16'd0;
            hdr_last_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            hdr_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            rem_q       <= rem_d;
            hdr_last_q  <= hdr_last_d;
            hdr_valid_q <= hdr_valid_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            hdr_err_q   <= hdr_err_d;
            len_err_q   <= len_err_d;
        end
    end

    // Ingress is refused while reset is held so no byte is half-accepted.
    assign beat_c             = trdy_c && !i_reset;
    assign s_axis_trdy        = beat_c;
    assign m_udp_hdr_tvalid   = hdr_valid_q;
    assign m_udp_src_port     = src_q;
    assign m_udp_dst_port     = dst_q;
    assign m_udp_length       = len_q;
    assign m_udp_hdr_checksum = csum_q;
    assign m_axis_tdata       = m_data_q;
    assign m_axis_tvalid      = m_valid_q;
    assign m_axis_tlast       = m_last_q;
    assign o_hdr_err          = hdr_err_q;
    assign o_len_err          = len_err_q;

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- Receive-side counterpart of udp_tx.
- Consumes a byte-wide AXI-Stream carrying one UDP datagram per frame, with the IP layer already stripped.
- Extracts the 8-byte UDP header and presents it on a valid/ready header channel.
- Forwards the payload on a registered AXI-Stream master, enforcing the UDP length field.

Parameters:
AXI_DATA_WIDTH, 8, stream data width in bits; only 8 is supported.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
s_axis_tdata  in  8  ingress datagram byte
s_axis_tvalid  in  1  ingress valid
s_axis_tlast  in  1  last byte of datagram
s_axis_trdy  out  1  ingress ready
m_udp_hdr_tvalid  out  1  header fields valid
m_udp_hdr_trdy  in  1  header accepted by sink
m_udp_src_port  out  16  source port
m_udp_dst_port  out  16  destination port
m_udp_length  out  16  UDP length field (header + payload bytes)
m_udp_hdr_checksum  out  16  checksum field, forwarded unchecked
m_axis_tdata  out  8  payload byte
m_axis_tvalid  out  1  payload valid
m_axis_tlast  out  1  last payload byte
m_axis_trdy  in  1  payload ready
o_hdr_err  out  1  one-cycle pulse: truncated header or length < 8
o_len_err  out  1  one-cycle pulse: payload length disagrees with tlast position

Behaviour:
- Reset (async assert, sync deassert):
  - state=HDR, byte counter=0.
  - All m_* valids, tlast, errors and header fields are 0; s_axis_trdy=0 during reset.
  - Reset mid-frame discards the partial datagram. The first byte after reset is treated as header byte 0.
- Byte order: network big-endian, MSB first.
  - Bytes 0-1 src, 2-3 dst, 4-5 length, 6-7 checksum.
- Transfer rule: a beat transfers on tvalid&&trdy. Counters advance only on transfers.
- State HDR:
  - s_axis_trdy=1. Bytes are captured into header registers; the counter increments 0..7.
  - tlast on byte index <7: pulse o_hdr_err, reset counter, stay in HDR. No header is emitted.
  - Byte 7 accepted: compute length.
    - length<8: pulse o_hdr_err. Go to DROP (or stay in HDR if byte 7 had tlast).
    - Otherwise load payload remaining = length-8 (16-bit), assert m_udp_hdr_tvalid the next cycle, and go to HDR_OUT.
- State HDR_OUT:
  - s_axis_trdy=0. Header fields stay stable while m_udp_hdr_tvalid=1; it deasserts the cycle after m_udp_hdr_trdy=1.
  - On accept:
    - remaining==0 and byte 7 had tlast: go to HDR.
    - remaining==0 without tlast: pulse o_len_err, go to DROP.
    - remaining>0 and byte 7 had tlast: pulse o_len_err, go to HDR; no payload beats.
    - Otherwise go to PAYLOAD.
- State PAYLOAD:
  - One-entry registered output stage; s_axis_trdy = !m_axis_tvalid || m_axis_trdy.
  - Each accepted byte loads the output register and decrements remaining.
  - m_axis_tlast is set on the byte where remaining reaches 0, or on an input tlast, whichever comes first.
  - Early tlast (remaining>0): forward with tlast, pulse o_len_err, go to HDR.
  - remaining reaches 0 without tlast: pulse o_len_err, go to DROP.
  - Both on the same byte: normal end, go to HDR.
  - Output data/valid/tlast hold while m_axis_tvalid && !m_axis_trdy.
  - Full throughput of 1 byte/cycle when m_axis_trdy=1; ingress-to-egress latency is 1 cycle.
- State DROP: s_axis_trdy=1, bytes discarded, no output. Ingress tlast returns to HDR.
- The next datagram's header may be accepted while the final payload byte is still held in the output register.
- o_hdr_err and o_len_err are never asserted together; each is registered and high for exactly 1 cycle.

Test Plan:
- Single datagram (src 0x1234, dst 0x5678, len 0x000C, csum 0xABCD, payload DE AD BE EF with tlast) -> header fields exact, one header handshake, 4 payload beats with tlast on 0xEF, no errors.
- Zero-payload datagram (len 0x0008, tlast on byte 7) -> header emitted, no m_axis beats, no errors. A back-to-back second datagram parses correctly.
- Truncated header (tlast on byte 4) -> o_hdr_err pulses once, no header valid. The following good datagram parses.
- len 0x0010 with tlast after 3 payload bytes -> 3 beats, last has tlast, o_len_err once. len 0x000A with 5 payload bytes -> 2 beats with tlast on the 2nd, o_len_err, 3 bytes dropped.
- Random m_axis_trdy/m_udp_hdr_trdy throttling over 100 random datagrams (1-64 byte payloads) -> output matches scoreboard, data held stable while stalled.
- Assert i_reset mid-payload -> all valids 0 immediately. A post-reset datagram is received correctly from its first byte.
